counter: RTL and testbench
==========================

COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter WIDTH, default 4, counter and output width in bits.
REQ-002 Parameter MAX_COUNT, default 15, terminal count; legal range 0 to 2^WIDTH-1.
REQ-003 Parameter RESET_VALUE, default 0, value loaded on reset and on wrap; legal range 0 to MAX_COUNT.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 Port out  output  WIDTH  current count value, driven directly from a register.
REQ-007 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-008 The block SHALL have no other ports.

Function
REQ-009 On each rising clk edge with reset=0 and out<MAX_COUNT, out SHALL become out+1.
REQ-010 On a rising clk edge with reset=0 and out==MAX_COUNT, out SHALL become RESET_VALUE (wrap-around, no stall).
REQ-011 If out holds a value above MAX_COUNT (illegal state, not reachable in normal operation), the next rising edge with reset=0 SHALL load RESET_VALUE.
REQ-012 The increment SHALL be modulo 2^WIDTH internally; no carry-out or overflow flag is produced.
REQ-013 Latency: a count change SHALL appear on out in the same cycle as the rising edge that causes it, with no extra pipeline stage.
REQ-014 out SHALL change only on rising clk edges; it SHALL be glitch-free between edges, and there is no combinational path from any input to out.
REQ-015 The count SHALL advance on every cycle; there is no enable or hold input.

Reset
REQ-016 On a rising clk edge with reset=1, out SHALL become RESET_VALUE regardless of its current value.
REQ-017 Reset SHALL take priority over increment and wrap on the same edge.
REQ-018 Asserting reset between clock edges SHALL have no effect until the next rising edge.
REQ-019 Reset asserted mid-count SHALL take effect on the next rising edge; counting SHALL resume from RESET_VALUE on the first rising edge after reset deasserts.
REQ-020 Holding reset high for multiple cycles SHALL keep out at RESET_VALUE.
REQ-021 Before the first reset, out is undefined; the bench SHALL apply reset before checking any values.

Verification (defaults: WIDTH=4, MAX_COUNT=15, RESET_VALUE=0; clk period 2 ns, first rising edge at 1 ns)
REQ-022 Initial reset: reset=1 from 0 to 7 ns -> out=0 after the 1, 3 and 5 ns edges and remains 0.
REQ-023 Count-up: reset=0 at 7 ns -> out=1 at the 9 ns edge, 2 at 11 ns, and 11 at the 29 ns edge.
REQ-024 Mid-count reset: reset=1 from 30 to 40 ns -> out=0 at the 31 ns edge, held at 0 through the 39 ns edge.
REQ-025 Resume: reset=0 at 40 ns -> out=1 at the 41 ns edge, incrementing by 1 on each subsequent edge.
REQ-026 Wrap: continue counting -> out=15 at the 15th edge after release (69 ns) and out=0 at the 16th edge (71 ns), then 1 at the next edge.
REQ-027 Async-immunity: pulse reset high for 0.5 ns between edges -> out continues incrementing unaffected.

Source files
------------

// File: rtl/counter.sv
`timescale 1ns/1ps
// counter: free-running up-counter with wrap-around to a programmable value.
//
// Parameters
//   WIDTH       - counter/output width in bits
//   MAX_COUNT   - terminal count (0 .. 2^WIDTH-1)
//   RESET_VALUE - value loaded on reset and on wrap (0 .. MAX_COUNT)
//
// Ports
//   clk   - sole clock; all state changes on its rising edge
//   reset - synchronous, active-high reset (priority over counting)
//   out   - current count, driven directly from the count register
module counter #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned MAX_COUNT   = 15,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] out
);

  localparam logic [WIDTH-1:0] MaxVal   = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ResetVal = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] count_q, count_d;

  // Anything at or above the terminal count reloads, so an illegal value
  // above MAX_COUNT recovers on the next edge instead of running on.
  always_comb begin
    count_d = count_q + WIDTH'(1);
    if (count_q >= MaxVal) begin
      count_d = ResetVal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= ResetVal;
    end else begin
      count_q <= count_d;
    end
  end

  assign out = count_q;

endmodule

// File: tb/tb_counter.sv
`timescale 1ns/1ps
// tb_counter: directed timeline checks plus randomized reset/glitch stimulus,
// compared against a spec-level model for a default and a non-default instance.
module tb_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] out_a;
  logic [2:0] out_b;

  int tests = 0;
  int fails = 0;
  int model_a = 0;
  int model_b = 2;

  counter #(
    .WIDTH      (4),
    .MAX_COUNT  (15),
    .RESET_VALUE(0)
  ) u_a (
    .clk  (clk),
    .reset(reset),
    .out  (out_a)
  );

  counter #(
    .WIDTH      (3),
    .MAX_COUNT  (5),
    .RESET_VALUE(2)
  ) u_b (
    .clk  (clk),
    .reset(reset),
    .out  (out_b)
  );

  // Period 2 ns, first rising edge at 1 ns.
  always #1 clk = ~clk;

  // Next count after one rising edge.
  function automatic int next_val(int cur, bit rst, int maxc, int rv, int w);
    if (rst) return rv;
    if (cur >= maxc) return rv;
    return (cur + 1) % (1 << w);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait for a rising edge, advance the models, sample 0.5 ns later.
  task automatic edge_check(input string tag);
    @(posedge clk);
    model_a = next_val(model_a, reset, 15, 0, 4);
    model_b = next_val(model_b, reset, 5, 2, 3);
    #0.5;
    check({tag, "_a"}, {28'b0, out_a}, model_a);
    check({tag, "_b"}, {29'b0, out_b}, model_b);
  endtask

  initial begin
    // Initial reset, edges at 1, 3, 5 ns.
    for (int i = 0; i < 3; i++) begin
      edge_check("init");
      check("init_const", {28'b0, out_a}, 0);
    end
    #1.5;                       // t = 7 ns
    reset = 1'b0;
    // Count-up, edges 9..29 ns -> 1..11.
    for (int i = 1; i <= 11; i++) begin
      edge_check("count");
      check("count_const", {28'b0, out_a}, i);
    end
    #0.5;                       // t = 30 ns
    reset = 1'b1;
    // Mid-count reset, edges 31..39 ns.
    for (int i = 0; i < 5; i++) begin
      edge_check("midrst");
      check("midrst_const", {28'b0, out_a}, 0);
    end
    #0.5;                       // t = 40 ns
    reset = 1'b0;
    // Resume and wrap: 1 at 41 ns, 15 at 69 ns, 0 at 71 ns, 1 at 73 ns.
    for (int k = 1; k <= 17; k++) begin
      edge_check("wrap");
      check("wrap_const", {28'b0, out_a}, k % 16);
    end
    // Reset pulse entirely between edges must be ignored.
    #0.5;                       // t = 74 ns
    reset = 1'b1;
    #0.5;
    reset = 1'b0;
    edge_check("glitch");
    check("glitch_const", {28'b0, out_a}, 2);
    #1;                         // between edges, value must hold
    check("hold_between", {28'b0, out_a}, 2);

    // Randomized phase: sparse resets plus between-edge reset glitches.
    for (int n = 0; n < 300; n++) begin
      logic r;
      r = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) begin
        #0.2;
        reset = ~reset;
        #0.2;
        reset = ~reset;
      end
      reset = r;
      edge_check("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
